sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single external SRAM between the AVR port (address from the serial address register, data on the AVR bus) and the SNES cartridge port. Arbitrates between the two requesters round-robin and drives SRAM chip-enable, output-enable and write-enable with a configurable strobe width. Sits between the requester-side logic and the SRAM pins; the tri-state pad is instantiated at the top level using `sram_dout_en`.

## Interface
- `ADDR_W`, 21: SRAM address width.
- `DATA_W`, 8: SRAM data width.
- `WAIT_CYCLES`, 2: cycles `sram_oe_n`/`sram_we_n` are held low; legal range ≥1.
- `avr_clk` in 1: single system clock; all logic on the rising edge.
- `avr_reset` in 1: reset, synchronous, active-high.
- `avr_req` in 1: AVR access request; level, held until `avr_ack`.
- `avr_wr` in 1: 1 = write, 0 = read; stable while `avr_req` is high.
- `avr_addr` in ADDR_W: AVR address, from the shift register.
- `avr_wdata` in DATA_W: AVR write data.
- `avr_rdata` out DATA_W: AVR read data; valid from the `avr_ack` cycle until the next AVR read completes.
- `avr_ack` out 1: one-cycle completion pulse for AVR.
- `snes_req`, `snes_wr`, `snes_addr`, `snes_wdata`, `snes_rdata`, `snes_ack`: same as the AVR set, for the SNES port.
- `sram_addr` out ADDR_W: registered SRAM address.
- `sram_dout` out DATA_W: write data to the pad.
- `sram_dout_en` out 1: pad drive enable.
- `sram_din` in DATA_W: read data from the pad.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1: SRAM strobes, active-low.
- `busy` out 1: high in any state other than IDLE.
- `grant` out 1: owner of the current or last access; 0 = AVR, 1 = SNES.

## Operation
- States: IDLE, SETUP, STROBE, HOLD. Wait counter width is clog2(WAIT_CYCLES+1).
- **IDLE:** if any request is pending, select one, set `grant`, and capture its addr, wr and wdata into internal registers. Go to SETUP.
- **Arbitration:**
  - Only one requester pending: it wins.
  - Both pending: the one not in `last_grant` wins.
  - `last_grant` updates on every grant. Reset value is SNES, so AVR wins the first tie.
- **SETUP (1 cycle):**
  - `sram_ce_n`=0 and `sram_addr` is valid.
  - For writes, `sram_dout_en`=1 and `sram_dout` = captured data.
  - Load the wait counter with WAIT_CYCLES. Go to STROBE.
- **STROBE (WAIT_CYCLES cycles):**
  - Reads: `sram_oe_n`=0. Writes: `sram_we_n`=0.
  - Decrement the counter each cycle. When it reaches 1, go to HOLD.
  - For reads, latch `sram_din` into the owner's rdata on that same edge.
- **HOLD (1 cycle):**
  - `sram_oe_n`=`sram_we_n`=1, `sram_ce_n`=0; `sram_dout_en` stays 1 for writes (data hold).
  - The owner's ack is 1.
  - Next state: if the other requester is pending, grant it and go directly to SETUP. Otherwise go to IDLE. The just-served requester is masked from arbitration in HOLD.
- **Request dropped before ack:** the access completes and ack is still issued. There is no abort.
- **Reset:** `avr_reset` high at any edge, including mid-access, forces the following on the next edge:
  - state = IDLE;
  - `sram_ce_n`/`sram_oe_n`/`sram_we_n` = 1, `sram_dout_en` = 0;
  - `sram_addr` = 0, `sram_dout` = 0, both rdata = 0;
  - both acks = 0, `busy` = 0, `grant` = 0, `last_grant` = SNES.
  
  The aborted access gets no ack.

## Timing
- Cycle 0 = the cycle in which the request is seen high in IDLE.
- Cycle 1 = SETUP, cycles 2..WAIT_CYCLES+1 = STROBE, cycle WAIT_CYCLES+2 = HOLD with ack.
- Request-to-ack latency: WAIT_CYCLES+2 (4 at the default).
- Back-to-back accesses to alternating owners: one every WAIT_CYCLES+2 cycles.
- Same requester re-requesting: it passes through IDLE, adding 1 cycle.
- All outputs are registered. Neither strobe is ever low outside STROBE.
- `sram_dout_en` is never high during a read or while `sram_oe_n`=0.

## Structure
- Shared package `sram_arb_pkg` holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD);
  - the GRANT_AVR=0 and GRANT_SNES=1 constants;
  - the default ADDR_W/DATA_W.
- One natural sub-module: `rr_arbiter2`, a two-requester round-robin arbiter with mask input and `last_grant` register.

## Test plan
1. **AVR read:** after reset, AVR reads 0x1F00AA with `sram_din`=0xAA and WAIT_CYCLES=2. Expect `sram_ce_n` low in cycles 1–4, `sram_oe_n` low in cycles 2–3, `avr_rdata`=0xAA and `avr_ack` pulse in cycle 4, `sram_dout_en` 0 throughout.
2. **SNES write:** SNES writes 0x55 to 0x000123. Expect `sram_dout`=0x55 with `sram_dout_en` high in cycles 1–4, `sram_we_n` low in cycles 2–3, `snes_ack` in cycle 4, `grant`=1.
3. **Simultaneous requests:** both requests rise in the same cycle and are held. Expect AVR served first (ack in cycle 4), SNES SETUP in cycle 5 with no IDLE gap, `snes_ack` in cycle 8.
4. **Reset mid-write:** `avr_reset` pulsed in the first STROBE cycle of a write. Next edge: all strobes 1, `sram_dout_en`=0, `busy`=0, and no ack is ever issued.
5. **Request dropped:** `avr_req` dropped in cycle 2 of a read. Expect `avr_ack` still in cycle 4 and no second access.
6. **Fairness:** AVR requests continuously while SNES is pending. Expect SNES granted after at most one AVR access, with `grant` alternating 0,1,0,1.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 21;
  localparam int DEF_DATA_W = 8;

  localparam logic GRANT_AVR  = 1'b0;
  localparam logic GRANT_SNES = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 = AVR, bit 1 = SNES.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       update,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic       last_grant;
  logic [1:0] eligible;

  always_comb begin
    eligible  = req & ~mask;
    gnt_valid = |eligible;
    gnt_idx   = GRANT_AVR;
    if (eligible == 2'b11) gnt_idx = ~last_grant;
    else if (eligible[1])  gnt_idx = GRANT_SNES;
  end

  always_ff @(posedge clk) begin
    if (reset)                      last_grant <= GRANT_SNES;
    else if (update && gnt_valid)   last_grant <= gnt_idx;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one external SRAM between the AVR and SNES ports with round-robin
// arbitration and registered CE/OE/WE strobes of configurable width.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              avr_clk,
  input  logic              avr_reset,
  input  logic              avr_req,
  input  logic              avr_wr,
  input  logic [ADDR_W-1:0] avr_addr,
  input  logic [DATA_W-1:0] avr_wdata,
  output logic [DATA_W-1:0] avr_rdata,
  output logic              avr_ack,
  input  logic              snes_req,
  input  logic              snes_wr,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic [DATA_W-1:0] snes_wdata,
  output logic [DATA_W-1:0] snes_rdata,
  output logic              snes_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              grant
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  arb_state_t        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              cur_wr, cur_wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dout_d, avr_rdata_d, snes_rdata_d;
  logic              dout_en_d, ce_n_d, oe_n_d, we_n_d;
  logic              avr_ack_d, snes_ack_d, grant_d;
  logic [1:0]        arb_mask;
  logic              arb_update, arb_valid, arb_idx;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .clk       (avr_clk),
    .reset     (avr_reset),
    .req       ({snes_req, avr_req}),
    .mask      (arb_mask),
    .update    (arb_update),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  assign sel_wr    = arb_idx ? snes_wr    : avr_wr;
  assign sel_addr  = arb_idx ? snes_addr  : avr_addr;
  assign sel_wdata = arb_idx ? snes_wdata : avr_wdata;

  // Every output is computed one cycle ahead and registered, so the pins
  // reflect the state being entered.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    cur_wr_d     = cur_wr;
    addr_d       = sram_addr;
    dout_d       = sram_dout;
    dout_en_d    = sram_dout_en;
    ce_n_d       = sram_ce_n;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    avr_ack_d    = 1'b0;
    snes_ack_d   = 1'b0;
    avr_rdata_d  = avr_rdata;
    snes_rdata_d = snes_rdata;
    grant_d      = grant;
    arb_mask     = 2'b00;
    arb_update   = 1'b0;

    unique case (state)
      IDLE: arb_update = 1'b1;
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_W'(WAIT_CYCLES);
        oe_n_d  = cur_wr;
        we_n_d  = ~cur_wr;
      end
      STROBE: begin
        if (cnt == CNT_W'(1)) begin
          state_d = HOLD;
          if (!cur_wr) begin
            if (grant == GRANT_SNES) snes_rdata_d = sram_din;
            else                     avr_rdata_d  = sram_din;
          end
          if (grant == GRANT_SNES) snes_ack_d = 1'b1;
          else                     avr_ack_d  = 1'b1;
        end else begin
          cnt_d  = cnt - CNT_W'(1);
          oe_n_d = cur_wr;
          we_n_d = ~cur_wr;
        end
      end
      HOLD: begin
        arb_mask   = (grant == GRANT_SNES) ? 2'b10 : 2'b01;
        arb_update = 1'b1;
        state_d    = IDLE;
        ce_n_d     = 1'b1;
        dout_en_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (arb_update && arb_valid) begin
      state_d   = SETUP;
      grant_d   = arb_idx;
      cur_wr_d  = sel_wr;
      addr_d    = sel_addr;
      dout_en_d = sel_wr;
      ce_n_d    = 1'b0;
      if (sel_wr) dout_d = sel_wdata;
    end
  end

  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cur_wr       <= 1'b0;
      sram_addr    <= '0;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      avr_ack      <= 1'b0;
      snes_ack     <= 1'b0;
      avr_rdata    <= '0;
      snes_rdata   <= '0;
      grant        <= GRANT_AVR;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      cur_wr       <= cur_wr_d;
      sram_addr    <= addr_d;
      sram_dout    <= dout_d;
      sram_dout_en <= dout_en_d;
      sram_ce_n    <= ce_n_d;
      sram_oe_n    <= oe_n_d;
      sram_we_n    <= we_n_d;
      avr_ack      <= avr_ack_d;
      snes_ack     <= snes_ack_d;
      avr_rdata    <= avr_rdata_d;
      snes_rdata   <= snes_rdata_d;
      grant        <= grant_d;
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scenario bench for sram_arbiter with an ack-driven scoreboard.
module tb_sram_arbiter;

  localparam int AW = 21;
  localparam int DW = 8;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          avr_reset;
  logic          avr_req, avr_wr, snes_req, snes_wr;
  logic [AW-1:0] avr_addr, snes_addr, sram_addr;
  logic [DW-1:0] avr_wdata, snes_wdata, avr_rdata, snes_rdata;
  logic [DW-1:0] sram_dout, sram_din;
  logic          avr_ack, snes_ack, sram_dout_en;
  logic          sram_ce_n, sram_oe_n, sram_we_n, busy, grant;

  int checks = 0;
  int errors = 0;

  exp_t          avr_q[$];
  exp_t          snes_q[$];
  exp_t          e;
  logic [AW-1:0] seen_raddr, seen_waddr;
  logic [DW-1:0] seen_wdata;

  // SRAM stand-in: read data is the low byte of the address.
  assign sram_din = sram_addr[DW-1:0];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut (
    .avr_clk(clk), .avr_reset(avr_reset),
    .avr_req(avr_req), .avr_wr(avr_wr), .avr_addr(avr_addr),
    .avr_wdata(avr_wdata), .avr_rdata(avr_rdata), .avr_ack(avr_ack),
    .snes_req(snes_req), .snes_wr(snes_wr), .snes_addr(snes_addr),
    .snes_wdata(snes_wdata), .snes_rdata(snes_rdata), .snes_ack(snes_ack),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
    .sram_din(sram_din), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .busy(busy), .grant(grant)
  );

  // Scoreboard and pin invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!sram_oe_n) begin
      seen_raddr = sram_addr;
      checks++;
      if (sram_dout_en !== 1'b0 || sram_we_n !== 1'b1 || sram_ce_n !== 1'b0) begin
        errors++;
        $display("FAIL oe_invariant: dout_en=%b we_n=%b ce_n=%b, required 0 1 0", sram_dout_en, sram_we_n, sram_ce_n);
      end
    end
    if (!sram_we_n) begin
      seen_waddr = sram_addr;
      seen_wdata = sram_dout;
      checks++;
      if (sram_dout_en !== 1'b1 || sram_ce_n !== 1'b0) begin
        errors++;
        $display("FAIL we_invariant: dout_en=%b ce_n=%b, required 1 0", sram_dout_en, sram_ce_n);
      end
    end
    if (avr_ack === 1'b1) begin
      checks++;
      if (avr_q.size() == 0) begin
        errors++;
        $display("FAIL avr_unexpected_ack: ack seen with nothing outstanding");
      end else begin
        e = avr_q.pop_front();
        checks++;
        if (grant !== 1'b0) begin
          errors++;
          $display("FAIL avr_ack_grant: got %b, required 0", grant);
        end
        checks++;
        if (e.wr && (seen_waddr !== e.addr || seen_wdata !== e.data)) begin
          errors++;
          $display("FAIL avr_write: got addr %h data %h, required %h %h", seen_waddr, seen_wdata, e.addr, e.data);
        end else if (!e.wr && (avr_rdata !== e.data || seen_raddr !== e.addr)) begin
          errors++;
          $display("FAIL avr_read: got rdata %h addr %h, required %h %h", avr_rdata, seen_raddr, e.data, e.addr);
        end
      end
    end
    if (snes_ack === 1'b1) begin
      checks++;
      if (snes_q.size() == 0) begin
        errors++;
        $display("FAIL snes_unexpected_ack: ack seen with nothing outstanding");
      end else begin
        e = snes_q.pop_front();
        checks++;
        if (grant !== 1'b1) begin
          errors++;
          $display("FAIL snes_ack_grant: got %b, required 1", grant);
        end
        checks++;
        if (e.wr && (seen_waddr !== e.addr || seen_wdata !== e.data)) begin
          errors++;
          $display("FAIL snes_write: got addr %h data %h, required %h %h", seen_waddr, seen_wdata, e.addr, e.data);
        end else if (!e.wr && (snes_rdata !== e.data || seen_raddr !== e.addr)) begin
          errors++;
          $display("FAIL snes_read: got rdata %h addr %h, required %h %h", snes_rdata, seen_raddr, e.data, e.addr);
        end
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    avr_reset = 1'b1;
    avr_req = 0; avr_wr = 0; avr_addr = '0; avr_wdata = '0;
    snes_req = 0; snes_wr = 0; snes_addr = '0; snes_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, avr_ack, snes_ack, busy, grant} !== 8'b1110_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 11100000", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, avr_ack, snes_ack, busy, grant});
    end
    checks++;
    if (sram_addr !== '0 || sram_dout !== '0 || avr_rdata !== '0 || snes_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr %h dout %h ar %h sr %h, required all 0", sram_addr, sram_dout, avr_rdata, snes_rdata);
    end
    avr_reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_avr_read;
    avr_req = 1; avr_wr = 0; avr_addr = 21'h1F00AA;
    avr_q.push_back('{wr: 1'b0, addr: 21'h1F00AA, data: 8'hAA});
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      checks++;
      if (sram_ce_n !== (c == 5) || sram_oe_n !== !(c == 2 || c == 3) || sram_dout_en !== 1'b0 || avr_ack !== (c == 4)) begin
        errors++;
        $display("FAIL avr_read_c%0d: got ce_n %b oe_n %b dout_en %b ack %b, required %b %b 0 %b", c, sram_ce_n, sram_oe_n, sram_dout_en, avr_ack, c == 5, !(c == 2 || c == 3), c == 4);
      end
      if (c == 1) begin
        checks++;
        if (sram_addr !== 21'h1F00AA) begin
          errors++;
          $display("FAIL avr_read_addr: got %h, required 1f00aa", sram_addr);
        end
      end
      if (c == 4) begin
        checks++;
        if (avr_rdata !== 8'hAA) begin
          errors++;
          $display("FAIL avr_read_data: got %h, required aa", avr_rdata);
        end
        avr_req = 0;
      end
    end
  endtask

  task automatic test_snes_write;
    snes_req = 1; snes_wr = 1; snes_addr = 21'h000123; snes_wdata = 8'h55;
    snes_q.push_back('{wr: 1'b1, addr: 21'h000123, data: 8'h55});
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      checks++;
      if (sram_dout !== 8'h55 || sram_dout_en !== 1'b1 || sram_we_n !== !(c == 2 || c == 3) || snes_ack !== (c == 4) || grant !== 1'b1) begin
        errors++;
        $display("FAIL snes_write_c%0d: got dout %h en %b we_n %b ack %b grant %b, required 55 1 %b %b 1", c, sram_dout, sram_dout_en, sram_we_n, snes_ack, grant, !(c == 2 || c == 3), c == 4);
      end
    end
    snes_req = 0; snes_wr = 0;
    next_cycle();
  endtask

  task automatic test_simultaneous;
    avr_req = 1; avr_wr = 1; avr_addr = 21'h000077; avr_wdata = 8'h3C;
    snes_req = 1; snes_wr = 0; snes_addr = 21'h000033;
    avr_q.push_back('{wr: 1'b1, addr: 21'h000077, data: 8'h3C});
    snes_q.push_back('{wr: 1'b0, addr: 21'h000033, data: 8'h33});
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      checks++;
      if (sram_ce_n !== 1'b0 || busy !== 1'b1 || grant !== (c >= 5) || avr_ack !== (c == 4) || snes_ack !== (c == 8) || sram_dout_en !== (c <= 4)) begin
        errors++;
        $display("FAIL simultaneous_c%0d: got ce_n %b busy %b grant %b aack %b sack %b en %b", c, sram_ce_n, busy, grant, avr_ack, snes_ack, sram_dout_en);
      end
      if (c == 4) begin avr_req = 0; avr_wr = 0; end
      if (c == 8) snes_req = 0;
    end
    next_cycle();
  endtask

  task automatic test_dropped;
    avr_req = 1; avr_wr = 0; avr_addr = 21'h000042;
    avr_q.push_back('{wr: 1'b0, addr: 21'h000042, data: 8'h42});
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (c == 2) avr_req = 0;
      checks++;
      if (avr_ack !== (c == 4) || busy !== (c <= 4) || sram_ce_n !== (c >= 5)) begin
        errors++;
        $display("FAIL dropped_c%0d: got ack %b busy %b ce_n %b, required %b %b %b", c, avr_ack, busy, sram_ce_n, c == 4, c <= 4, c >= 5);
      end
    end
  endtask

  task automatic test_back_to_back;
    avr_req = 1; avr_wr = 0; avr_addr = 21'h000011;
    avr_q.push_back('{wr: 1'b0, addr: 21'h000011, data: 8'h11});
    avr_q.push_back('{wr: 1'b0, addr: 21'h000011, data: 8'h11});
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      checks++;
      if (avr_ack !== (c == 4 || c == 9) || busy !== (c != 5)) begin
        errors++;
        $display("FAIL back_to_back_c%0d: got ack %b busy %b, required %b %b", c, avr_ack, busy, c == 4 || c == 9, c != 5);
      end
      if (c == 9) avr_req = 0;
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_write;
    avr_req = 1; avr_wr = 1; avr_addr = 21'h0ABCDE; avr_wdata = 8'h99;
    next_cycle();
    next_cycle();
    checks++;
    if (sram_we_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_write_strobe: got we_n %b, required 0", sram_we_n);
    end
    avr_reset = 1;
    next_cycle();
    avr_reset = 0; avr_req = 0; avr_wr = 0;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, busy, grant, avr_ack} !== 7'b1110_000) begin
      errors++;
      $display("FAIL mid_write_ctrl: got %b, required 1110000", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, busy, grant, avr_ack});
    end
    checks++;
    if (sram_addr !== '0 || sram_dout !== '0 || avr_rdata !== '0 || snes_rdata !== '0) begin
      errors++;
      $display("FAIL mid_write_data: got addr %h dout %h ar %h sr %h, required all 0", sram_addr, sram_dout, avr_rdata, snes_rdata);
    end
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      checks++;
      if (avr_ack !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_write_no_ack: got ack %b busy %b, required 0 0", avr_ack, busy);
      end
    end
  endtask

  task automatic test_fairness;
    logic [3:0] grants;
    int n;
    grants = '0;
    n = 0;
    avr_req = 1; avr_wr = 0; avr_addr = 21'h0000A1;
    snes_req = 1; snes_wr = 0; snes_addr = 21'h0000B2;
    for (int i = 0; i < 2; i++) begin
      avr_q.push_back('{wr: 1'b0, addr: 21'h0000A1, data: 8'hA1});
      snes_q.push_back('{wr: 1'b0, addr: 21'h0000B2, data: 8'hB2});
    end
    for (int c = 0; c < 40 && n < 4; c++) begin
      next_cycle();
      if (avr_ack || snes_ack) begin
        grants[n] = grant;
        n++;
        if (n == 4) begin avr_req = 0; snes_req = 0; end
      end
    end
    avr_req = 0; snes_req = 0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL fairness_timeout: got %0d acks, required 4", n);
    end
    checks++;
    if (grants !== 4'b1010) begin
      errors++;
      $display("FAIL fairness_order: got grants (first at bit0) %b, required 1010", grants);
    end
    repeat (3) next_cycle();
  endtask

  initial begin
    test_reset();
    test_avr_read();
    test_snes_write();
    test_simultaneous();
    test_dropped();
    test_back_to_back();
    test_reset_mid_write();
    test_fairness();
    checks++;
    if (avr_q.size() != 0 || snes_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding: got %0d avr %0d snes pending, required 0 0", avr_q.size(), snes_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
